// File: rtl/overlay_compositor_if.sv
// Framebuffer write port: valid/ready handshake carrying a back-buffer address and pixel.
interface overlay_compositor_if #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 24
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/overlay_compositor.sv
// Double-buffered, down-scaled framebuffer overlay composited onto the VGA pixel stream.
// Three-stage pipeline (address, RAM read, composite) with frame-synchronous buffer swap.
module overlay_compositor #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned X_START    = 0,
    parameter int unsigned Y_START    = 0,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned CW         = 8,
    parameter int unsigned NCH        = 3
) (
    input  logic                i_vga_clk,
    input  logic                i_rst,
    input  logic [12:0]         i_h_cnt,
    input  logic [12:0]         i_v_cnt,
    input  logic [NCH*CW-1:0]   i_pix,
    input  logic [1:0]          i_mode,
    input  logic [NCH*CW-1:0]   i_key,
    input  logic                i_swap_req,
    output logic                o_swap_pending,
    output logic                o_front_buf,
    output logic [NCH*CW-1:0]   o_pix,
    overlay_compositor_if.slave wr_if
);

    localparam int unsigned DW    = NCH * CW;
    localparam int unsigned FB_W  = H_ACTIVE >> SCALE_LOG2;
    localparam int unsigned FB_H  = V_ACTIVE >> SCALE_LOG2;
    localparam int unsigned FB_N  = FB_W * FB_H;
    localparam int unsigned AW    = $clog2(FB_N);
    localparam int unsigned DEPTH = 2 * FB_N;
    localparam int unsigned RAW   = $clog2(DEPTH);
    localparam int unsigned X_END = X_START + H_ACTIVE;
    localparam int unsigned Y_END = Y_START + V_ACTIVE;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_t;

    swap_state_t r_state;
    swap_state_t w_state_nxt;
    logic        r_front;
    logic        w_front_nxt;
    logic        r_swap_pending;
    logic        r_wr_ready;
    logic        w_frame_start;

    logic            w_act;
    logic [12:0]     w_x;
    logic [12:0]     w_y;
    logic [12:0]     w_fx;
    logic [12:0]     w_fy;
    logic [AW-1:0]   w_lin;
    logic [RAW-1:0]  w_rd_idx;
    logic [RAW-1:0]  w_wr_idx;
    logic            w_wr_en;

    logic [DW-1:0]   r_mem [DEPTH];

    logic [RAW-1:0]  r_s0_addr;
    logic            r_s0_act;
    logic [DW-1:0]   r_s0_pix;
    logic [DW-1:0]   r_s1_fb;
    logic            r_s1_act;
    logic [DW-1:0]   r_s1_pix;
    logic [DW-1:0]   r_pix;

    logic [CW:0]     w_sum [NCH];
    logic [DW-1:0]   w_blend;
    logic [DW-1:0]   w_comp;

    assign w_frame_start = (i_h_cnt == 13'd0) && (i_v_cnt == 13'd0);

    // Swap FSM: state register
    always_ff @(posedge i_vga_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_wr_ready     <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_front        <= w_front_nxt;
            r_swap_pending <= (w_state_nxt == ST_PENDING);
            r_wr_ready     <= (w_state_nxt != ST_PENDING);
        end
    end

    // Swap FSM: a queued swap retires on the frame-start cycle; requests while queued are absorbed
    always_comb begin
        w_state_nxt = r_state;
        w_front_nxt = r_front;
        case (r_state)
            ST_IDLE: begin
                if (i_swap_req) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_frame_start) begin
                    w_state_nxt = ST_IDLE;
                    w_front_nxt = ~r_front;
                end
            end
        endcase
    end

    assign w_act = (i_h_cnt >= 13'(X_START)) && ({1'b0, i_h_cnt} < 14'(X_END)) &&
                   (i_v_cnt >= 13'(Y_START)) && ({1'b0, i_v_cnt} < 14'(Y_END));

    assign w_x   = i_h_cnt - 13'(X_START);
    assign w_y   = i_v_cnt - 13'(Y_START);
    assign w_fx  = w_x >> SCALE_LOG2;
    assign w_fy  = w_y >> SCALE_LOG2;
    assign w_lin = AW'(w_fx) + AW'(w_fy) * AW'(FB_W);

    // Buffers sit at word offsets 0 and FB_N so the RAM stays exactly 2*FB_N deep.
    // The frame-start pixel already reads from the buffer that becomes front on this edge.
    assign w_rd_idx = w_act ? ((w_front_nxt ? RAW'(FB_N) : RAW'(0)) + RAW'(w_lin)) : RAW'(0);
    assign w_wr_idx = (r_front ? RAW'(0) : RAW'(FB_N)) + RAW'(wr_if.wr_addr);
    assign w_wr_en  = wr_if.wr_valid && r_wr_ready && (RAW'(wr_if.wr_addr) < RAW'(FB_N));

    always_ff @(posedge i_vga_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= wr_if.wr_data;
        end
    end

    // S0 address/flag capture, S1 RAM read, S2 composite
    always_ff @(posedge i_vga_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0_addr <= '0;
            r_s0_act  <= 1'b0;
            r_s0_pix  <= '0;
            r_s1_fb   <= '0;
            r_s1_act  <= 1'b0;
            r_s1_pix  <= '0;
            r_pix     <= '0;
        end else begin
            r_s0_addr <= w_rd_idx;
            r_s0_act  <= w_act;
            r_s0_pix  <= i_pix;
            r_s1_fb   <= r_mem[r_s0_addr];
            r_s1_act  <= r_s0_act;
            r_s1_pix  <= r_s0_pix;
            r_pix     <= w_comp;
        end
    end

    // Per-channel average with a carry bit so no channel spills into its neighbour
    for (genvar g = 0; g < NCH; g++) begin : g_blend
        assign w_sum[g] = {1'b0, r_s1_fb[g*CW +: CW]} + {1'b0, r_s1_pix[g*CW +: CW]};
        assign w_blend[g*CW +: CW] = w_sum[g][CW:1];
    end

    always_comb begin
        w_comp = r_s1_pix;
        if (r_s1_act) begin
            case (i_mode)
                2'd0: w_comp = r_s1_pix;
                2'd1: w_comp = (r_s1_fb == i_key) ? r_s1_pix : r_s1_fb;
                2'd2: w_comp = w_blend;
                2'd3: w_comp = r_s1_fb;
            endcase
        end
    end

    assign o_pix          = r_pix;
    assign o_front_buf    = r_front;
    assign o_swap_pending = r_swap_pending;
    assign wr_if.wr_ready = r_wr_ready;

endmodule
